// File: rtl/ws2812_chain_driver.sv
// WS2812 daisy-chain driver: host-written pixel buffer, GRB serialisation with
// parameterised bit timing and latch period. Optional macro WS2812_AUTO_REFRESH_EN.
module ws2812_chain_driver #(
  parameter int NUM_LEDS  = 8,
  parameter int ADDR_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
  parameter int T0H_CYC   = 20,
  parameter int T0L_CYC   = 43,
  parameter int T1H_CYC   = 40,
  parameter int T1L_CYC   = 23,
  parameter int RESET_CYC = 2500,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_rgb,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  output logic              ws2812_data
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

  localparam logic [CNT_W-1:0]  T0H_LAST  = CNT_W'(T0H_CYC - 1);
  localparam logic [CNT_W-1:0]  T0L_LAST  = CNT_W'(T0L_CYC - 1);
  localparam logic [CNT_W-1:0]  T1H_LAST  = CNT_W'(T1H_CYC - 1);
  localparam logic [CNT_W-1:0]  T1L_LAST  = CNT_W'(T1L_CYC - 1);
  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0]  DONE_AT   = CNT_W'((RESET_CYC >= 2) ? RESET_CYC - 2 : 0);
  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(NUM_LEDS - 1);
  localparam logic              RST_ONE   = (RESET_CYC == 1);

  state_t             state;
  logic [23:0]        pixel [NUM_LEDS];
  logic [23:0]        shift_reg;
  logic [4:0]         bit_cnt;
  logic [ADDR_W-1:0]  pix_cnt;
  logic [CNT_W-1:0]   cnt;
  logic               high_phase;

  logic [ADDR_W-1:0]  load_idx;
  logic [23:0]        load_rgb;
  logic [23:0]        load_grb;
  logic [CNT_W-1:0]   high_last;
  logic [CNT_W-1:0]   low_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LEDS; i++) pixel[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++)
        if (wr_en && wr_addr == ADDR_W'(i)) pixel[i] <= wr_rgb;
    end
  end

  // Same-cycle write to the pixel being loaded is forwarded so the new value wins.
  always_comb begin
    load_idx = (state == LOAD) ? '0 : pix_cnt + ADDR_W'(1);
    load_rgb = pixel[load_idx];
    if (wr_en && wr_addr == load_idx) load_rgb = wr_rgb;
    load_grb = {load_rgb[15:8], load_rgb[23:16], load_rgb[7:0]};
  end

  assign high_last = shift_reg[23] ? T1H_LAST : T0H_LAST;
  assign low_last  = shift_reg[23] ? T1L_LAST : T0L_LAST;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      pix_cnt     <= '0;
      cnt         <= '0;
      high_phase  <= 1'b0;
      ws2812_data <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          ws2812_data <= 1'b0;
`ifdef WS2812_AUTO_REFRESH_EN
          state <= LOAD;
          busy  <= 1'b1;
`else
          if (frame_start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
`endif
        end
        LOAD: begin
          shift_reg   <= load_grb;
          bit_cnt     <= '0;
          pix_cnt     <= '0;
          cnt         <= '0;
          high_phase  <= 1'b1;
          ws2812_data <= 1'b1;
          busy        <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (high_phase) begin
            if (cnt == high_last) begin
              high_phase  <= 1'b0;
              ws2812_data <= 1'b0;
              cnt         <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (cnt != low_last) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            // End of a bit: the next bit's high phase starts with no gap cycle.
            cnt <= '0;
            if (bit_cnt != 5'd23) begin
              bit_cnt     <= bit_cnt + 5'd1;
              shift_reg   <= {shift_reg[22:0], 1'b0};
              high_phase  <= 1'b1;
              ws2812_data <= 1'b1;
            end else if (pix_cnt != LAST_PIX) begin
              bit_cnt     <= '0;
              pix_cnt     <= pix_cnt + ADDR_W'(1);
              shift_reg   <= load_grb;
              high_phase  <= 1'b1;
              ws2812_data <= 1'b1;
            end else begin
              state      <= LATCH;
              frame_done <= RST_ONE;
            end
          end
        end
        LATCH: begin
          ws2812_data <= 1'b0;
          if (cnt == RST_LAST) begin
            cnt  <= '0;
            busy <= 1'b0;
`ifdef WS2812_AUTO_REFRESH_EN
            state <= LOAD;
`else
            state <= IDLE;
`endif
          end else begin
            // frame_done is registered, so it is raised one cycle ahead of the last.
            cnt        <= cnt + CNT_W'(1);
            frame_done <= !RST_ONE && (cnt == DONE_AT);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Scoreboard bench for ws2812_chain_driver (NUM_LEDS=2): expected bits and frame
// ends are queued by the stimulus and checked by a pulse-decoding monitor.
module tb_ws2812_chain_driver;
  localparam int NL  = 2;
  localparam int T0H = 20;
  localparam int T0L = 43;
  localparam int T1H = 40;
  localparam int T1L = 23;
  localparam int RST = 2500;
  localparam int FRAME_END = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [0:0]  wr_addr = '0;
  logic [23:0] wr_rgb = '0;
  logic        frame_start = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        ws2812_data;

  ws2812_chain_driver #(
    .NUM_LEDS(NL), .T0H_CYC(T0H), .T0L_CYC(T0L), .T1H_CYC(T1H), .T1L_CYC(T1L),
    .RESET_CYC(RST), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb),
    .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .ws2812_data(ws2812_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int th(input int b);
    return (b != 0) ? T1H : T0H;
  endfunction

  function automatic int tl(input int b);
    return (b != 0) ? T1L : T0L;
  endfunction

  // Monitor: decodes pulses on the data line and pops expectations.
  int   cyc = 0;
  logic last_d = 1'b0;
  int   rise_cyc = 0, fall_cyc = 0, cur_bit = 0, prev_bit = 0, pop_v = 0;
  bit   have_fall = 1'b0, chk_busy_drop = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      last_d        = 1'b0;
      have_fall     = 1'b0;
      chk_busy_drop = 1'b0;
    end else begin
      if (chk_busy_drop) begin
        check("busy_drop", int'(busy), 0);
        chk_busy_drop = 1'b0;
      end
      if (ws2812_data && !last_d) begin
        if (have_fall) check("bit_low", cyc - fall_cyc, tl(prev_bit));
        have_fall = 1'b0;
        check("busy_in_frame", int'(busy), 1);
        cur_bit = 0;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_bit: got a bit, expected none (t=%0t)", $time);
        end else begin
          pop_v = exp_q.pop_front();
          if (pop_v == FRAME_END) begin
            n_checks++;
            $display("FAIL bit_order: got a bit, expected frame_done (t=%0t)", $time);
          end else cur_bit = pop_v;
        end
        rise_cyc = cyc;
      end
      if (!ws2812_data && last_d) begin
        check("bit_high", cyc - rise_cyc, th(cur_bit));
        fall_cyc  = cyc;
        prev_bit  = cur_bit;
        have_fall = 1'b1;
      end
      if (frame_done) begin
        pop_v = (exp_q.size() == 0) ? -1 : exp_q.pop_front();
        check("frame_done_expected", pop_v, FRAME_END);
        // Last bit low phase plus latch, with frame_done in the final latch cycle.
        check("latch_len", have_fall ? cyc - fall_cyc : -1, tl(prev_bit) + RST - 1);
        check("busy_at_done", int'(busy), 1);
        have_fall     = 1'b0;
        chk_busy_drop = 1'b1;
      end
      last_d = ws2812_data;
    end
  end

  task automatic write_px(input int a, input logic [23:0] rgb);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 1'(a);
    wr_rgb  = rgb;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push_frame(input logic [23:0] p0, input logic [23:0] p1);
    logic [23:0] px [2];
    logic [23:0] grb;
    px[0] = p0;
    px[1] = p1;
    for (int i = 0; i < NL; i++) begin
      grb = {px[i][15:8], px[i][23:16], px[i][7:0]};
      for (int b = 23; b >= 0; b--) exp_q.push_back(int'(grb[b]));
    end
    exp_q.push_back(FRAME_END);
  endtask

  // Returns at the negedge after the first data rise.
  task automatic start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("data_in_load", int'(ws2812_data), 0);
    @(negedge clk);
    check("first_rise", int'(ws2812_data), 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 7000);
    if (!frame_done) begin
      n_checks++;
      $display("FAIL frame_timeout: got no frame_done, expected one within 7000 cycles");
    end
  endtask

  int n_wait;
  int rises;
  int k;
  logic prev_d;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", int'(ws2812_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Colour frame: GRB 00 FF 00 | 00 00 FF
    write_px(0, 24'hFF0000);
    write_px(1, 24'h0000FF);
    push_frame(24'hFF0000, 24'h0000FF);
    start_frame();
    wait_done(n_wait);

    // All-zero frame length: asserting negedge to frame_done = 1+1+48*63+2499+... = 5525
    write_px(0, 24'h000000);
    write_px(1, 24'h000000);
    push_frame(24'h0, 24'h0);
    start_frame();
    wait_done(n_wait);
    check("frame_len", n_wait + 2, 1 + 48 * (T0H + T0L) + RST);

    // Writes after pixel 0 is loaded: frame 1 has old pixel0, new pixel1.
    write_px(0, 24'hFF0000);
    write_px(1, 24'h0000FF);
    push_frame(24'hFF0000, 24'h123456);
    start_frame();
    write_px(0, 24'h00FF00);
    write_px(1, 24'h123456);
    wait_done(n_wait);
    push_frame(24'h00FF00, 24'h123456);
    start_frame();
    wait_done(n_wait);

    // frame_start mid-SEND is ignored.
    push_frame(24'h00FF00, 24'h123456);
    start_frame();
    repeat (100) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_done(n_wait);
    repeat (300) @(negedge clk);
    check("ignored_start_busy", int'(busy), 0);
    check("ignored_start_queue", exp_q.size(), 0);

    // Reset during the high phase of pixel 1, bit 10 (35th rise of the frame).
    push_frame(24'h00FF00, 24'h123456);
    start_frame();
    rises  = 1;
    prev_d = 1'b1;
    k      = 0;
    while (rises < 35 && k < 6000) begin
      @(negedge clk);
      k++;
      if (ws2812_data && !prev_d) rises++;
      prev_d = ws2812_data;
    end
    check("reached_bit34", rises, 35);
    repeat (5) @(negedge clk);
    check("pre_reset_high", int'(ws2812_data), 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_data", int'(ws2812_data), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(frame_done), 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (3500) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    push_frame(24'h0, 24'h0);
    start_frame();
    wait_done(n_wait);

    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
